// File: rtl/handshake_arbiter_if.sv
// Point-to-point data link shared by source, arbiter and drain blocks.
// dir1 drives port1 and reads port2; dir2 is the mirror view.
interface handshake #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] port1;
   logic [WIDTH-1:0] port2;

   modport dir1 (output port1, input port2);
   modport dir2 (input port1, output port2);
endinterface

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter muxing NREQ handshake links onto one shared link.
// Define HS_ARB_TIMEOUT_EN to preempt an owner after MAX_BURST granted cycles.
//
// state | meaning
// IDLE  | no grant active, waiting for any req
// GRANT | gnt/owner valid, datapath routed to owner
module handshake_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         last,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    busy,
   handshake.dir2                  src [NREQ-1:0],
   handshake.dir1                  dst
);
   localparam int OW = $clog2(NREQ);

   typedef enum logic {IDLE, GRANT} state_t;

   if (NREQ < 2 || NREQ > 16 || MAX_BURST < 1) begin : g_bad_param
      $error("handshake_arbiter: NREQ must be 2..16 and MAX_BURST >= 1");
   end

   state_t          state;
   logic [OW-1:0]   ptr;
   logic [OW-1:0]   ptr_rel;
   logic [OW:0]     win_idle;
   logic [OW:0]     win_rel;
   logic            timeout;
   logic            release_now;

   // Returns {found, index}: first set request scanning p, p+1, ... with wrap.
   function automatic logic [OW:0] pick(input logic [NREQ-1:0] r, input logic [OW-1:0] p);
      logic [OW:0]   res;
      logic [OW-1:0] jj;
      int            j;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j  = (int'(p) + k) % NREQ;
         jj = OW'(j);
         if (r[jj]) res = {1'b1, jj};
      end
      return res;
   endfunction

`ifdef HS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_BURST + 1);
   logic [CW-1:0] cnt;
   assign timeout = (cnt == CW'(MAX_BURST));
`else
   assign timeout = 1'b0;
`endif

   assign ptr_rel     = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign win_idle    = pick(req, ptr);
   assign win_rel     = pick(req, ptr_rel);
   assign release_now = !req[owner] || last[owner] || timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         owner <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
`ifdef HS_ARB_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_idle[OW]) begin
                  state <= GRANT;
                  gnt   <= NREQ'(1) << win_idle[OW-1:0];
                  owner <= win_idle[OW-1:0];
                  busy  <= 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
                  cnt   <= CW'(1);
`endif
               end
            end
            GRANT: begin
               if (release_now) begin
                  ptr <= ptr_rel;
                  // A releasing owner still requesting sits last in the scan order.
                  if (win_rel[OW]) begin
                     gnt   <= NREQ'(1) << win_rel[OW-1:0];
                     owner <= win_rel[OW-1:0];
`ifdef HS_ARB_TIMEOUT_EN
                     cnt   <= CW'(1);
`endif
                  end else begin
                     state <= IDLE;
                     gnt   <= '0;
                     busy  <= 1'b0;
                  end
               end else begin
`ifdef HS_ARB_TIMEOUT_EN
                  cnt <= timeout ? cnt : cnt + 1'b1;
`endif
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   logic [WIDTH-1:0] src_data [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_route
      assign src_data[i]  = src[i].port1;
      assign src[i].port2 = (busy && owner == OW'(i)) ? dst.port2 : '0;
   end

   assign dst.port1 = busy ? src_data[owner] : '0;
endmodule

// File: tb/tb_handshake_arbiter.sv
// Scoreboard bench for handshake_arbiter: driver queues expected grant state,
// monitor checks grant, owner and routed data at each falling edge.
module tb_handshake_arbiter;
   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;

   logic [31:0]       src_val [4];
   logic [31:0]       dst_p2;
   logic [3:0][31:0]  src_p2;

   handshake #(.WIDTH(32)) src_if [3:0] ();
   handshake #(.WIDTH(32)) dst_if ();

   for (genvar g = 0; g < 4; g++) begin : g_links
      assign src_if[g].port1 = src_val[g];
      assign src_p2[g]       = src_if[g].port2;
   end
   assign dst_if.port2 = dst_p2;

   handshake_arbiter #(.NREQ(4), .WIDTH(32), .MAX_BURST(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .last  (last),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy),
      .src   (src_if),
      .dst   (dst_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct packed {
      int         due;
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       busy;
      logic       chk_own;
      logic [3:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic string tname(input logic [3:0] t);
      case (t)
         4'd0: return "reset_hold";
         4'd1: return "reset_grant";
         4'd2: return "rotation";
         4'd3: return "data_route";
         4'd4: return "drop_idle";
         4'd5: return "timeout";
         4'd6: return "async_reset";
         4'd7: return "post_reset";
         default: return "misc";
      endcase
   endfunction

   task automatic push(input int due, input logic [3:0] g, input logic chk_own, input logic [3:0] tag);
      exp_t e;
      e.due     = due;
      e.gnt     = g;
      e.owner   = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
      e.busy    = |g;
      e.chk_own = chk_own | (|g);
      e.tag     = tag;
      sb.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t             e;
      logic [31:0]      exp_d1;
      logic [3:0][31:0] exp_p2;
      logic             ok;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            exp_d1 = e.busy ? src_val[e.owner] : 32'h0;
            for (int i = 0; i < 4; i++)
               exp_p2[i] = (e.busy && e.owner == 2'(i)) ? dst_p2 : 32'h0;
            ok = (e.due == cycle) && (gnt === e.gnt) && (busy === e.busy) &&
                 (!e.chk_own || owner === e.owner) &&
                 (dst_if.port1 === exp_d1) && (src_p2 === exp_p2);
            n_tests++;
            if (!ok) begin
               n_fail++;
               $display("FAIL %s cyc=%0d due=%0d: gnt=%b/%b owner=%0d/%0d busy=%b/%b d1=%h/%h p2=%h/%h (got/want)",
                        tname(e.tag), cycle, e.due, gnt, e.gnt, owner, e.owner, busy, e.busy,
                        dst_if.port1, exp_d1, src_p2, exp_p2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b0;
      req  = 4'b0000;
      last = 4'b0000;
      for (int i = 0; i < 4; i++) src_val[i] = 32'hA0A0_0000 | 32'(i + 1);
      dst_p2 = 32'h0000_1234;

      #2 rst = 1'b1;
      req = 4'b1111;
      tick;
      push(cycle, 4'b0000, 1'b1, 4'd0);
      tick;
      rst = 1'b0;
      push(cycle + 1, 4'b0001, 1'b1, 4'd1);

      for (int k = 0; k < 4; k++) begin
         tick;
         last = 4'(1 << k);
         push(cycle + 1, 4'(1 << ((k + 1) % 4)), 1'b1, 4'd2);
      end

      tick;
      src_val[2] = 32'hDEAD_BEEF;
      last = 4'b0001;
      push(cycle + 1, 4'b0010, 1'b1, 4'd3);
      tick;
      last = 4'b0010;
      push(cycle + 1, 4'b0100, 1'b1, 4'd3);
      for (int k = 0; k < 2; k++) begin
         tick;
         last = 4'b0000;
         push(cycle + 1, 4'b0100, 1'b1, 4'd3);
      end

      tick; req = 4'b1000; push(cycle + 1, 4'b1000, 1'b1, 4'd4);
      tick;                push(cycle + 1, 4'b1000, 1'b1, 4'd4);
      tick; req = 4'b0000; push(cycle + 1, 4'b0000, 1'b0, 4'd4);
      tick;                push(cycle + 1, 4'b0000, 1'b0, 4'd4);
      tick; req = 4'b0111; push(cycle + 1, 4'b0001, 1'b1, 4'd4);
      tick; last = 4'b0001; push(cycle + 1, 4'b0010, 1'b1, 4'd4);
      tick; last = 4'b0010; push(cycle + 1, 4'b0100, 1'b1, 4'd4);
      tick; last = 4'b0100; req = 4'b0000; push(cycle + 1, 4'b0000, 1'b0, 4'd4);

      tick;
      last = 4'b0000;
      req  = 4'b0011;
      push(cycle + 1, 4'b0001, 1'b1, 4'd5);
      for (int k = 2; k <= 16; k++) begin
         tick;
         last = (k == 2) ? 4'b0010 : 4'b0000;
         push(cycle + 1, 4'b0001, 1'b1, 4'd5);
      end
`ifdef HS_ARB_TIMEOUT_EN
      tick;
      push(cycle + 1, 4'b0010, 1'b1, 4'd5);
`else
      for (int k = 17; k <= 24; k++) begin
         tick;
         push(cycle + 1, 4'b0001, 1'b1, 4'd5);
      end
`endif
      tick; req = 4'b0000; push(cycle + 1, 4'b0000, 1'b0, 4'd5);

      tick; req = 4'b0010; push(cycle + 1, 4'b0010, 1'b1, 4'd6);
      tick;
      tick;
      rst = 1'b1;
      push(cycle, 4'b0000, 1'b1, 4'd6);
      tick;
      rst = 1'b0;
      req = 4'b0101;
      push(cycle + 1, 4'b0001, 1'b1, 4'd7);
      tick; req = 4'b0000; push(cycle + 1, 4'b0000, 1'b0, 4'd7);

      for (int k = 0; k < 5 && sb.size() > 0; k++) tick;
      tick;
      if (sb.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
